// File: rtl/instr_fetch.sv
// Program-counter and fetch sequencer feeding the control decoder.
// Runs a program from StartAddr, follows LUT-based branches and counts retired instructions.
module instr_fetch #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Jump,
    input  logic             BranchEn,
    input  logic [1:0]       TargSel,
    input  logic             Ack,
    input  logic             LutWrEn,
    input  logic [1:0]       LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCnt
);

    localparam int unsigned LUT_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] lut [LUT_N];

    // Branch target table; a same-cycle branch reads the pre-write value.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < int'(LUT_N); i++) begin
                lut[i] <= '0;
            end
        end else if (LutWrEn) begin
            lut[LutAddr] <= LutData;
        end
    end

    // Fetch FSM with registered PC, counter and state decodes.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            ProgCtr  <= '0;
            InstrCnt <= '0;
            Running  <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state    <= RUN;
                        ProgCtr  <= StartAddr;
                        InstrCnt <= '0;
                        Running  <= 1'b1;
                        Done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        if (InstrCnt != {CNT_W{1'b1}}) begin
                            InstrCnt <= InstrCnt + CNT_W'(1);
                        end
                        if (Ack) begin
                            state   <= DONE;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                        end else if (BranchEn && Jump) begin
                            ProgCtr <= lut[TargSel];
                        end else begin
                            ProgCtr <= ProgCtr + PC_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!Start) begin
                        state   <= IDLE;
                        Running <= 1'b0;
                        Done    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset/start, branches, LUT write collision,
// ack/stall interaction, PC wrap, mid-run reset and counter saturation.
module tb_instr_fetch;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 4;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic             Stall;
    logic             Jump;
    logic             BranchEn;
    logic [1:0]       TargSel;
    logic             Ack;
    logic             LutWrEn;
    logic [1:0]       LutAddr;
    logic [PC_W-1:0]  LutData;
    logic [PC_W-1:0]  ProgCtr;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] InstrCnt;

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Jump(Jump), .BranchEn(BranchEn), .TargSel(TargSel),
        .Ack(Ack), .LutWrEn(LutWrEn), .LutAddr(LutAddr), .LutData(LutData),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done), .InstrCnt(InstrCnt)
    );

    always #5 Clk = ~Clk;

    // Advance one edge; outputs are then sampled and inputs changed 1ns later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0; StartAddr = '0; Stall = 1'b0; Jump = 1'b0;
        BranchEn = 1'b0; TargSel = '0; Ack = 1'b0; LutWrEn = 1'b0; LutAddr = '0; LutData = '0;
        step();
        step();
        checks++;
        if (ProgCtr !== 10'h000 || Running !== 1'b0 || Done !== 1'b0 || InstrCnt !== 4'h0) begin
            failures++;
            $display("FAIL reset_state pc=%h run=%b done=%b cnt=%h exp pc=000 run=0 done=0 cnt=0",
                     ProgCtr, Running, Done, InstrCnt);
        end
        Reset = 1'b1; StartAddr = 10'h010; Start = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 10'h010 || Running !== 1'b1) begin
            failures++;
            $display("FAIL start_load pc=%h run=%b exp pc=010 run=1", ProgCtr, Running);
        end
        step();
        checks++;
        if (ProgCtr !== 10'h011) begin
            failures++;
            $display("FAIL seq_1 pc=%h exp 011", ProgCtr);
        end
        step();
        checks++;
        if (ProgCtr !== 10'h012 || InstrCnt !== 4'h2) begin
            failures++;
            $display("FAIL seq_2 pc=%h cnt=%h exp pc=012 cnt=2", ProgCtr, InstrCnt);
        end
    endtask

    task automatic test_branch();
        LutWrEn = 1'b1; LutAddr = 2'd2; LutData = 10'h3A0;
        step();                                  // pc 013
        LutWrEn = 1'b0;
        step();                                  // pc 014
        step();                                  // pc 015
        checks++;
        if (ProgCtr !== 10'h015) begin
            failures++;
            $display("FAIL pre_branch pc=%h exp 015", ProgCtr);
        end
        BranchEn = 1'b1; Jump = 1'b1; TargSel = 2'd2;
        step();
        checks++;
        if (ProgCtr !== 10'h3A0) begin
            failures++;
            $display("FAIL branch_taken pc=%h exp 3a0", ProgCtr);
        end
        Jump = 1'b0;
        step();
        checks++;
        if (ProgCtr !== 10'h3A1) begin
            failures++;
            $display("FAIL branch_not_taken pc=%h exp 3a1", ProgCtr);
        end
        BranchEn = 1'b0; TargSel = '0;
    endtask

    task automatic test_lut_collision();
        LutWrEn = 1'b1; LutAddr = 2'd1; LutData = 10'h040;
        step();                                  // pc 3a2, LUT[1]=040
        LutData = 10'h080;
        BranchEn = 1'b1; Jump = 1'b1; TargSel = 2'd1;
        step();
        checks++;
        if (ProgCtr !== 10'h040) begin
            failures++;
            $display("FAIL lut_old_value pc=%h exp 040", ProgCtr);
        end
        LutWrEn = 1'b0;
        step();
        checks++;
        if (ProgCtr !== 10'h080) begin
            failures++;
            $display("FAIL lut_new_value pc=%h exp 080", ProgCtr);
        end
        BranchEn = 1'b0; Jump = 1'b0; TargSel = '0;
    endtask

    task automatic test_ack_stall();
        Ack = 1'b1;
        step();
        Ack = 1'b0;
        step();                                  // Start still high: held in DONE
        checks++;
        if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 10'h080) begin
            failures++;
            $display("FAIL done_hold done=%b run=%b pc=%h exp done=1 run=0 pc=080", Done, Running, ProgCtr);
        end
        Start = 1'b0;
        step();
        checks++;
        if (Done !== 1'b0 || Running !== 1'b0) begin
            failures++;
            $display("FAIL done_to_idle done=%b run=%b exp 0 0", Done, Running);
        end
        StartAddr = 10'h000; Start = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 10'h000 || InstrCnt !== 4'h0 || Running !== 1'b1) begin
            failures++;
            $display("FAIL restart pc=%h cnt=%h run=%b exp pc=000 cnt=0 run=1", ProgCtr, InstrCnt, Running);
        end
        for (int i = 0; i < 5; i++) step();
        Ack = 1'b1; Stall = 1'b1;
        step();
        checks++;
        if (Running !== 1'b1 || Done !== 1'b0 || InstrCnt !== 4'h5 || ProgCtr !== 10'h005) begin
            failures++;
            $display("FAIL stall_over_ack run=%b done=%b cnt=%h pc=%h exp run=1 done=0 cnt=5 pc=005",
                     Running, Done, InstrCnt, ProgCtr);
        end
        Stall = 1'b0;
        step();
        checks++;
        if (Done !== 1'b1 || Running !== 1'b0 || InstrCnt !== 4'h6 || ProgCtr !== 10'h005) begin
            failures++;
            $display("FAIL ack_done done=%b run=%b cnt=%h pc=%h exp done=1 run=0 cnt=6 pc=005",
                     Done, Running, InstrCnt, ProgCtr);
        end
        Ack = 1'b0; Start = 1'b0;
        step();
        checks++;
        if (Done !== 1'b0 || Running !== 1'b0 || ProgCtr !== 10'h005 || InstrCnt !== 4'h6) begin
            failures++;
            $display("FAIL ack_idle done=%b run=%b pc=%h cnt=%h exp done=0 run=0 pc=005 cnt=6",
                     Done, Running, ProgCtr, InstrCnt);
        end
    endtask

    task automatic test_wrap_reset();
        StartAddr = 10'h3FF; Start = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 10'h3FF) begin
            failures++;
            $display("FAIL wrap_start pc=%h exp 3ff", ProgCtr);
        end
        step();
        checks++;
        if (ProgCtr !== 10'h000) begin
            failures++;
            $display("FAIL wrap pc=%h exp 000", ProgCtr);
        end
        step();                                  // pc 001
        Reset = 1'b0;
        step();
        checks++;
        if (ProgCtr !== 10'h000 || Running !== 1'b0 || Done !== 1'b0 || InstrCnt !== 4'h0) begin
            failures++;
            $display("FAIL midrun_reset pc=%h run=%b done=%b cnt=%h exp pc=000 run=0 done=0 cnt=0",
                     ProgCtr, Running, Done, InstrCnt);
        end
        Reset = 1'b1;
        step();                                  // Start still high: RUN at 3ff
        BranchEn = 1'b1; Jump = 1'b1; TargSel = 2'd1;
        step();
        checks++;
        if (ProgCtr !== 10'h000) begin
            failures++;
            $display("FAIL lut_cleared pc=%h exp 000", ProgCtr);
        end
        BranchEn = 1'b0; Jump = 1'b0; TargSel = '0;
    endtask

    task automatic test_saturation();
        Ack = 1'b1;
        step();
        Ack = 1'b0; Start = 1'b0;
        step();
        StartAddr = 10'h100; Start = 1'b1;
        step();
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (InstrCnt !== 4'hF) begin
            failures++;
            $display("FAIL cnt_reach_max cnt=%h exp f", InstrCnt);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (InstrCnt !== 4'hF || ProgCtr !== 10'h114) begin
            failures++;
            $display("FAIL cnt_saturate cnt=%h pc=%h exp cnt=f pc=114", InstrCnt, ProgCtr);
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_lut_collision();
        test_ack_stall();
        test_wrap_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
